// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and limits for the alarm scheduler
package alarm_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
   localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_RINGING  = 2'd2,
      ST_SNOOZE   = 2'd3
   } alarm_state_t;

   function automatic logic time_in_range(input logic [HOUR_W-1:0] h,
                                          input logic [MIN_W-1:0]  m);
      return (h <= MAX_HOUR) && (m <= MAX_MIN);
   endfunction

endpackage

// File: rtl/alarm_cfg_if.sv
// rtl/alarm_cfg_if.sv - set-request handshake, range check, set-point store and time load strobe
module alarm_cfg_if
   import alarm_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cfg_valid,
   input  logic              i_cfg_sel,
   input  logic [HOUR_W-1:0] i_cfg_hours,
   input  logic [MIN_W-1:0]  i_cfg_minutes,
   output logic              o_cfg_ready,
   output logic              o_cfg_err,
   output logic              o_alarm_wr,
   output logic              o_time_load,
   output logic [HOUR_W-1:0] o_time_load_hours,
   output logic [MIN_W-1:0]  o_time_load_minutes,
   output logic [HOUR_W-1:0] o_alarm_hours,
   output logic [MIN_W-1:0]  o_alarm_minutes
);

   logic              r_ready;
   logic              r_err;
   logic              r_load;
   logic [HOUR_W-1:0] r_load_hours;
   logic [MIN_W-1:0]  r_load_minutes;
   logic [HOUR_W-1:0] r_alarm_hours;
   logic [MIN_W-1:0]  r_alarm_minutes;
   logic              w_accept;
   logic              w_in_range;

   assign w_accept   = i_cfg_valid && r_ready;
   assign w_in_range = time_in_range(i_cfg_hours, i_cfg_minutes);
   // Combinational so the FSM can cancel an active event on the same edge the set-point changes.
   assign o_alarm_wr = w_accept && w_in_range && !i_cfg_sel;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ready         <= 1'b1;
         r_err           <= 1'b0;
         r_load          <= 1'b0;
         r_load_hours    <= '0;
         r_load_minutes  <= '0;
         r_alarm_hours   <= '0;
         r_alarm_minutes <= '0;
      end else begin
         r_ready <= !w_accept;
         r_err   <= w_accept && !w_in_range;
         r_load  <= w_accept && w_in_range && i_cfg_sel;
         if (w_accept && w_in_range && i_cfg_sel) begin
            r_load_hours   <= i_cfg_hours;
            r_load_minutes <= i_cfg_minutes;
         end
         if (o_alarm_wr) begin
            r_alarm_hours   <= i_cfg_hours;
            r_alarm_minutes <= i_cfg_minutes;
         end
      end
   end

   assign o_cfg_ready         = r_ready;
   assign o_cfg_err           = r_err;
   assign o_time_load         = r_load;
   assign o_time_load_hours   = r_load_hours;
   assign o_time_load_minutes = r_load_minutes;
   assign o_alarm_hours       = r_alarm_hours;
   assign o_alarm_minutes     = r_alarm_minutes;

endmodule

// File: rtl/alarm_sched_ctrl.sv
// rtl/alarm_sched_ctrl.sv - alarm ring/snooze/timeout FSM between user inputs and the timekeeper
module alarm_sched_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10,
   parameter int MAX_SNOOZES      = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_min_tick,
   input  logic [HOUR_W-1:0] i_cur_hours,
   input  logic [MIN_W-1:0]  i_cur_minutes,
   input  logic              i_alarm_en,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic              i_cfg_sel,
   input  logic [HOUR_W-1:0] i_cfg_hours,
   input  logic [MIN_W-1:0]  i_cfg_minutes,
   output logic              o_cfg_err,
   input  logic              i_snooze_btn,
   input  logic              i_dismiss_btn,
   output logic              o_time_load,
   output logic [HOUR_W-1:0] o_time_load_hours,
   output logic [MIN_W-1:0]  o_time_load_minutes,
   output logic [HOUR_W-1:0] o_alarm_hours,
   output logic [MIN_W-1:0]  o_alarm_minutes,
   output logic              o_alarm_out,
   output logic              o_snooze_active,
   output logic [1:0]        o_state
);

   localparam logic [3:0] SNZ_LOAD    = 4'(SNOOZE_MIN);
   localparam logic [4:0] RING_LIMIT  = 5'(RING_TIMEOUT_MIN);
   localparam logic [2:0] SNOOZE_LIM  = 3'(MAX_SNOOZES);

   alarm_state_t r_state;
   logic         r_alarm_out;
   logic         r_snooze_active;
   logic [3:0]   r_ring_cnt;
   logic [3:0]   r_snz_cnt;
   logic [2:0]   r_snooze_cnt;
   logic         w_alarm_wr;
   logic         w_match;
   logic [4:0]   w_ring_inc;

   alarm_cfg_if u_cfg (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_cfg_valid         (i_cfg_valid),
      .i_cfg_sel           (i_cfg_sel),
      .i_cfg_hours         (i_cfg_hours),
      .i_cfg_minutes       (i_cfg_minutes),
      .o_cfg_ready         (o_cfg_ready),
      .o_cfg_err           (o_cfg_err),
      .o_alarm_wr          (w_alarm_wr),
      .o_time_load         (o_time_load),
      .o_time_load_hours   (o_time_load_hours),
      .o_time_load_minutes (o_time_load_minutes),
      .o_alarm_hours       (o_alarm_hours),
      .o_alarm_minutes     (o_alarm_minutes)
   );

   assign w_match    = (i_cur_hours == o_alarm_hours) && (i_cur_minutes == o_alarm_minutes);
   assign w_ring_inc = {1'b0, r_ring_cnt} + 5'd1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= ST_DISARMED;
         r_alarm_out     <= 1'b0;
         r_snooze_active <= 1'b0;
         r_ring_cnt      <= '0;
         r_snz_cnt       <= '0;
         r_snooze_cnt    <= '0;
      end else if (!i_alarm_en) begin
         r_state         <= ST_DISARMED;
         r_alarm_out     <= 1'b0;
         r_snooze_active <= 1'b0;
      end else if (w_alarm_wr && (r_state == ST_RINGING || r_state == ST_SNOOZE)) begin
         r_state         <= ST_ARMED;
         r_alarm_out     <= 1'b0;
         r_snooze_active <= 1'b0;
         r_snooze_cnt    <= '0;
      end else begin
         case (r_state)
            ST_DISARMED: r_state <= ST_ARMED;
            ST_ARMED: begin
               if (i_min_tick && w_match) begin
                  r_state      <= ST_RINGING;
                  r_alarm_out  <= 1'b1;
                  r_ring_cnt   <= '0;
                  r_snooze_cnt <= '0;
               end
            end
            ST_RINGING: begin
               if (i_dismiss_btn) begin
                  r_state     <= ST_ARMED;
                  r_alarm_out <= 1'b0;
               end else if (i_snooze_btn && (r_snooze_cnt < SNOOZE_LIM)) begin
                  r_state         <= ST_SNOOZE;
                  r_alarm_out     <= 1'b0;
                  r_snooze_active <= 1'b1;
                  r_snz_cnt       <= SNZ_LOAD;
                  r_snooze_cnt    <= r_snooze_cnt + 3'd1;
               end else if (i_min_tick) begin
                  if (w_ring_inc >= RING_LIMIT) begin
                     r_state     <= ST_ARMED;
                     r_alarm_out <= 1'b0;
                  end
                  if (r_ring_cnt != 4'hF) r_ring_cnt <= w_ring_inc[3:0];
               end
            end
            ST_SNOOZE: begin
               if (i_dismiss_btn) begin
                  r_state         <= ST_ARMED;
                  r_snooze_active <= 1'b0;
               end else if (i_min_tick) begin
                  // A countdown of 1 (or an already-zero count) expires on this tick.
                  if (r_snz_cnt <= 4'd1) begin
                     r_state         <= ST_RINGING;
                     r_alarm_out     <= 1'b1;
                     r_snooze_active <= 1'b0;
                     r_ring_cnt      <= '0;
                     r_snz_cnt       <= '0;
                  end else begin
                     r_snz_cnt <= r_snz_cnt - 4'd1;
                  end
               end
            end
            default: r_state <= ST_DISARMED;
         endcase
      end
   end

   assign o_alarm_out     = r_alarm_out;
   assign o_snooze_active = r_snooze_active;
   assign o_state         = r_state;

endmodule

// File: tb/tb_alarm_sched_ctrl.sv
// tb/tb_alarm_sched_ctrl.sv - directed self-checking bench for alarm_sched_ctrl
module tb_alarm_sched_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       min_tick;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic       alarm_en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_sel;
   logic [4:0] cfg_hours;
   logic [5:0] cfg_minutes;
   logic       cfg_err;
   logic       snooze_btn;
   logic       dismiss_btn;
   logic       time_load;
   logic [4:0] time_load_hours;
   logic [5:0] time_load_minutes;
   logic [4:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       alarm_out;
   logic       snooze_active;
   logic [1:0] state_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alarm_sched_ctrl #(.SNOOZE_MIN(5), .RING_TIMEOUT_MIN(10), .MAX_SNOOZES(3)) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_min_tick          (min_tick),
      .i_cur_hours         (cur_hours),
      .i_cur_minutes       (cur_minutes),
      .i_alarm_en          (alarm_en),
      .i_cfg_valid         (cfg_valid),
      .o_cfg_ready         (cfg_ready),
      .i_cfg_sel           (cfg_sel),
      .i_cfg_hours         (cfg_hours),
      .i_cfg_minutes       (cfg_minutes),
      .o_cfg_err           (cfg_err),
      .i_snooze_btn        (snooze_btn),
      .i_dismiss_btn       (dismiss_btn),
      .o_time_load         (time_load),
      .o_time_load_hours   (time_load_hours),
      .o_time_load_minutes (time_load_minutes),
      .o_alarm_hours       (alarm_hours),
      .o_alarm_minutes     (alarm_minutes),
      .o_alarm_out         (alarm_out),
      .o_snooze_active     (snooze_active),
      .o_state             (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [4:0] h, input logic [5:0] m);
      min_tick = 1'b1; cur_hours = h; cur_minutes = m;
      step();
      min_tick = 1'b0;
   endtask

   task automatic cfg(input logic sel, input logic [4:0] h, input logic [5:0] m);
      cfg_valid = 1'b1; cfg_sel = sel; cfg_hours = h; cfg_minutes = m;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; alarm_en = 1'b0; min_tick = 1'b0; cur_hours = '0; cur_minutes = '0;
      cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_hours = '0; cfg_minutes = '0;
      snooze_btn = 1'b0; dismiss_btn = 1'b0;
      step(); step();
      chk("rst_state", state_o, 0);
      chk("rst_alarm_out", alarm_out, 0);
      chk("rst_alarm_hours", alarm_hours, 0);
      chk("rst_alarm_minutes", alarm_minutes, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_time_load", time_load, 0);
      chk("rst_cfg_err", cfg_err, 0);
      rst_n = 1'b1;
      step();
      chk("disarmed_wo_en", state_o, 0);

      // 1: arm, set alarm 07:30, ring on matching tick
      alarm_en = 1'b1;
      step();
      chk("armed", state_o, 1);
      cfg(1'b0, 5'd7, 6'd30);
      chk("sp_hours", alarm_hours, 7);
      chk("sp_minutes", alarm_minutes, 30);
      chk("ready_bubble", cfg_ready, 0);
      step();
      chk("ready_back", cfg_ready, 1);
      tick(5'd7, 6'd29);
      chk("no_ring_0729", state_o, 1);
      tick(5'd7, 6'd30);
      chk("ring_alarm_out", alarm_out, 1);
      chk("ring_state", state_o, 2);

      // 2: three snoozes of five minutes each, fourth snooze ignored
      for (int s = 0; s < 3; s++) begin
         snooze_btn = 1'b1;
         step();
         snooze_btn = 1'b0;
         chk("snz_state", state_o, 3);
         chk("snz_active", snooze_active, 1);
         chk("snz_alarm_out", alarm_out, 0);
         for (int t = 0; t < 4; t++) tick(5'd7, 6'd31);
         chk("snz_after4", state_o, 3);
         tick(5'd7, 6'd35);
         chk("rering_state", state_o, 2);
         chk("rering_out", alarm_out, 1);
      end
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      chk("snz4_ignored_state", state_o, 2);
      chk("snz4_ignored_out", alarm_out, 1);

      // 3: ring timeout after ten unanswered minutes
      for (int t = 0; t < 9; t++) tick(5'd7, 6'd50);
      chk("ring_after9", alarm_out, 1);
      tick(5'd8, 6'd0);
      chk("timeout_out", alarm_out, 0);
      chk("timeout_state", state_o, 1);
      tick(5'd7, 6'd31);
      chk("no_retrigger", state_o, 1);

      // 4: clock set requests
      cfg(1'b1, 5'd25, 6'd10);
      chk("err_pulse", cfg_err, 1);
      chk("err_no_load", time_load, 0);
      step();
      chk("err_clear", cfg_err, 0);
      cfg(1'b1, 5'd23, 6'd59);
      chk("load_pulse", time_load, 1);
      chk("load_hours", time_load_hours, 23);
      chk("load_minutes", time_load_minutes, 59);
      chk("load_no_err", cfg_err, 0);
      chk("load_state", state_o, 1);
      chk("load_sp_kept", alarm_hours, 7);
      step();
      chk("load_one_cycle", time_load, 0);

      // 5: midnight alarm, dismiss beats snooze
      cfg(1'b0, 5'd0, 6'd0);
      step();
      tick(5'd23, 6'd59);
      chk("no_ring_2359", state_o, 1);
      tick(5'd0, 6'd0);
      chk("ring_0000", alarm_out, 1);
      dismiss_btn = 1'b1; snooze_btn = 1'b1;
      step();
      dismiss_btn = 1'b0; snooze_btn = 1'b0;
      chk("dismiss_state", state_o, 1);
      chk("dismiss_out", alarm_out, 0);
      chk("dismiss_no_snz", snooze_active, 0);

      // 6: alarm_en drop, cancel by set-point write, async reset in SNOOZE
      tick(5'd0, 6'd0);
      chk("ring_again", state_o, 2);
      alarm_en = 1'b0;
      step();
      chk("dis_state", state_o, 0);
      chk("dis_out", alarm_out, 0);
      alarm_en = 1'b1;
      step();
      tick(5'd0, 6'd0);
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      chk("snz_before_cancel", state_o, 3);
      cfg(1'b0, 5'd6, 6'd15);
      chk("cancel_state", state_o, 1);
      chk("cancel_snz", snooze_active, 0);
      chk("cancel_sp", alarm_minutes, 15);
      tick(5'd6, 6'd15);
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      chk("snz_before_rst", snooze_active, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state_o, 0);
      chk("arst_snz", snooze_active, 0);
      chk("arst_sp", alarm_hours, 0);
      chk("arst_out", alarm_out, 0);
      step();
      rst_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
